keypad_scan: RTL
================

Name: keypad_scan

Overview:
- Upstream stage of the keypad decoder path. Scans a 4x4 matrix keypad by driving columns and sampling rows.
- Debounces press and release. Outputs a raw 4-bit key code `d`, a level `da` (key held and valid) and a one-cycle press strobe `kp`.
- Downstream edge detect, shift registers and the display multiplexer consume `d` and `da`. `kp` lets later designs drop the separate edge detector.

Parameters:
- SCAN_DIV, 1000, clock cycles per scan tick. Minimum 2.
- DEBOUNCE_CNT, 8, consecutive agreeing ticks needed to accept a press or a release. Minimum 1.
- REPEAT_TICKS, 250, ticks between auto-repeat strobes. Used only with KEYPAD_REPEAT_EN.

Ports:
- ck      input   1  clock; all logic on rising edge
- rst_n   input   1  synchronous reset, active-low
- y       input   4  row inputs, active-low, external pull-ups; y[r] low = key in row r and the driven column closed
- x       output  4  column drive, one-hot active-low (exactly one bit 0)
- d       output  4  key code {row[1:0], col[1:0]}; holds the last accepted key
- da      output  1  high while an accepted key is held (until release is debounced)
- kp      output  1  one-cycle strobe per accepted press (and per repeat when enabled)

Behaviour:
- Reset (rst_n=0 at a rising edge) sets: state=SCAN, col=0, x=4'b1110, d=0, da=0, kp=0, all counters 0. Reset mid-debounce or mid-hold aborts with no strobe.
- Prescaler counts 0..SCAN_DIV-1. `tick` is internal, high for one cycle when the count equals SCAN_DIV-1, then the count wraps to 0. All FSM decisions are taken on tick cycles only.
- `x` is a registered function of `col`: x = ~(4'b0001 << col).
- "Single-row hit" means exactly one bit of y is 0. Zero or two or more low bits count as no hit; multi-key ghosting is ignored.
- SCAN:
  - On tick with a single-row hit: latch row index and current col, clear deb_cnt, go to DEBOUNCE. col does not advance.
  - On tick with no hit: col = col+1 mod 4 (3 wraps to 0).
- DEBOUNCE (col frozen):
  - On tick, if y == ~(1<<row): deb_cnt+1.
  - When deb_cnt+1 == DEBOUNCE_CNT: go to HELD, set d={row,col} and da=1, pulse kp. These three outputs change together, registered, in the cycle after that tick.
  - On tick with any other y: deb_cnt=0, col=col+1 mod 4, back to SCAN, no output change.
- HELD (col frozen, da=1):
  - On tick, if y[row]=1: rel_cnt+1. If y[row]=0: rel_cnt=0.
  - When rel_cnt+1 == DEBOUNCE_CNT: da=0 in the following cycle, col=col+1 mod 4, go to SCAN. d retains its value.
  - Other rows are ignored while HELD; a second key pressed meanwhile is never reported.
- kp is never high for more than one consecutive cycle and is 0 outside the cycle after acceptance (and repeat ticks).
- Latency with no bounce, key closed before the tick of its column: kp/da rise DEBOUNCE_CNT ticks after the first sampling tick, plus 1 cycle.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - HELD keeps rep_cnt, cleared on entry to HELD.
  - On each tick in HELD with y[row]=0, rep_cnt+1. When rep_cnt+1 == REPEAT_TICKS, kp pulses one cycle (d unchanged) and rep_cnt=0.
  - A release-debounce tick (y[row]=1) holds rep_cnt.
- Undefined: no rep_cnt logic; exactly one kp per accepted press. REPEAT_TICKS is unused.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3, REPEAT_TICKS=5):
- Reset: hold rst_n=0 for 2 cycles with y=4'b0000 -> x=1110, d=0, da=0, kp=0; release reset, y=1111 -> x steps 1110,1101,1011,0111,1110, changing every 4 cycles.
- Clean press of row 2 / col 1: y[2]=0 only while x=1101, held 40 cycles -> exactly one kp; d=4'b1001 and da=1, 3 ticks + 1 cycle after the first hit tick; x stays 1101 while held.
- Bounce: y[2] low for 1 tick, high for 1 tick, then low steadily (col 1) -> no kp during the glitch; scan resumes at col 2; the press is later accepted with d=1001, single kp.
- Release: after acceptance set y=1111 -> da falls 3 ticks + 1 cycle later; d stays 1001; x resumes at 1011.
- Ghost/multi: y=4'b0011 at any column -> no kp, da stays 0, scan keeps rotating.
- KEYPAD_REPEAT_EN defined, key held 20 ticks after acceptance -> kp at acceptance plus 4 repeat pulses, spaced 5 ticks apart; undefined -> exactly 1 kp.

Source files
------------

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad column scanner with press/release debounce.
// Define KEYPAD_REPEAT_EN to add auto-repeat kp strobes while a key is held.
module keypad_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 8,
  parameter int REPEAT_TICKS = 250
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic [3:0] y,
  output logic [3:0] x,
  output logic [3:0] d,
  output logic       da,
  output logic       kp
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CNT - 1);

  if (SCAN_DIV < 2) begin : g_chk_div
    $error("keypad_scan: SCAN_DIV must be >= 2");
  end
  if (DEBOUNCE_CNT < 1) begin : g_chk_deb
    $error("keypad_scan: DEBOUNCE_CNT must be >= 1");
  end
  if (REPEAT_TICKS < 1) begin : g_chk_rep
    $error("keypad_scan: REPEAT_TICKS must be >= 1");
  end

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  state_t        state;
  logic [PW-1:0] pre;
  logic          tick;
  logic [1:0]    col;
  logic [1:0]    col_inc;
  logic [1:0]    row;
  logic [1:0]    hit_row;
  logic          hit;
  logic          match;
  logic [DW-1:0] deb_cnt;
  logic [DW-1:0] rel_cnt;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_cnt;
`endif

  assign tick    = (pre == PRE_LAST);
  assign col_inc = col + 2'd1;
  assign match   = (y == ~(4'b0001 << row));

  // Exactly one low row is a hit; none or several (ghosting) is ignored.
  always_comb begin
    hit     = 1'b1;
    hit_row = 2'd0;
    case (y)
      4'b1110: hit_row = 2'd0;
      4'b1101: hit_row = 2'd1;
      4'b1011: hit_row = 2'd2;
      4'b0111: hit_row = 2'd3;
      default: hit = 1'b0;
    endcase
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      state   <= SCAN;
      col     <= 2'd0;
      x       <= 4'b1110;
      row     <= 2'd0;
      d       <= 4'd0;
      da      <= 1'b0;
      kp      <= 1'b0;
      deb_cnt <= '0;
      rel_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt <= '0;
`endif
    end else begin
      kp <= 1'b0;
      if (tick) begin
        unique case (state)
          SCAN: begin
            if (hit) begin
              row     <= hit_row;
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              col <= col_inc;
              x   <= ~(4'b0001 << col_inc);
            end
          end
          DEBOUNCE: begin
            if (match) begin
              if (deb_cnt == DEB_LAST) begin
                state   <= HELD;
                d       <= {row, col};
                da      <= 1'b1;
                kp      <= 1'b1;
                rel_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt <= '0;
`endif
              end else begin
                deb_cnt <= deb_cnt + DW'(1);
              end
            end else begin
              deb_cnt <= '0;
              col     <= col_inc;
              x       <= ~(4'b0001 << col_inc);
              state   <= SCAN;
            end
          end
          HELD: begin
            if (y[row]) begin
              if (rel_cnt == DEB_LAST) begin
                da      <= 1'b0;
                rel_cnt <= '0;
                col     <= col_inc;
                x       <= ~(4'b0001 << col_inc);
                state   <= SCAN;
              end else begin
                rel_cnt <= rel_cnt + DW'(1);
              end
            end else begin
              rel_cnt <= '0;
`ifdef KEYPAD_REPEAT_EN
              if (rep_cnt == REP_LAST) begin
                kp      <= 1'b1;
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_cnt + RW'(1);
              end
`endif
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule
